dec_output_buffer: RTL and testbench

- Downstream stage of the decryption top-level. Consumes the 8-bit decrypted character stream (data/valid from the output mux) in the clk_sys domain.
- Buffers characters in a show-ahead FIFO and frames them into messages using a terminator character.
- Presents them to a ready/valid sink, and reports per-message length and overflow status.

---
 rtl/dec_output_buffer_pkg.sv | 16 +
 rtl/dec_output_buffer_sync_fifo.sv | 61 ++++++
 rtl/dec_output_buffer.sv | 132 +++++++++++++
 tb/tb_dec_output_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec_output_buffer_pkg.sv
// rtl/dec_output_buffer_pkg.sv - shared constants and types for the decrypted-character output buffer
package dec_output_buffer_pkg;

    localparam logic [7:0] TERM_CHAR_DEF = 8'hFA;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_MSG = 1'b1
    } msg_state_t;

    // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer width.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dec_output_buffer_sync_fifo.sv
// rtl/dec_output_buffer_sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module dec_output_buffer_sync_fifo
    import dec_output_buffer_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = level_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // full is the pre-pop view, so a push into a full FIFO is refused even alongside a pop.
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    // Storage is cleared on reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dec_output_buffer.sv
// rtl/dec_output_buffer.sv - buffers decrypted characters and frames them into terminator-delimited messages
module dec_output_buffer
    import dec_output_buffer_pkg::*;
#(
    parameter int                DEPTH     = 16,
    parameter int                DWIDTH    = 8,
    parameter logic [DWIDTH-1:0] TERM_CHAR = TERM_CHAR_DEF,
    parameter int                LEN_W     = 16
) (
    input  logic                       clk_sys,
    input  logic                       rst_n,
    input  logic [DWIDTH-1:0]          data_i,
    input  logic                       valid_i,
    output logic [DWIDTH-1:0]          data_o,
    output logic                       last_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       full,
    output logic [level_w(DEPTH)-1:0]  level,
    output logic                       msg_done,
    output logic [LEN_W-1:0]           msg_len,
    output logic                       msg_err,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    msg_state_t        state, state_next;
    logic [LEN_W-1:0]  len_cnt, len_next;
    logic              err_flag, err_next;
    logic              close_msg;
    logic              is_term;
    logic              stray_term;
    logic              accept;
    logic              drop;
    logic              empty;
    logic [DWIDTH:0]   head;

    assign is_term = (data_i == TERM_CHAR);
    // A terminator with no open message is discarded without touching the FIFO or overflow.
    assign stray_term = (state == ST_IDLE) && is_term;
    assign accept     = valid_i && !full && !stray_term;
    assign drop       = valid_i && full && !stray_term;

    dec_output_buffer_sync_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .push  (accept),
        .wdata ({is_term, data_i}),
        .pop   (ready_i),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign valid_o = !empty;
    assign data_o  = head[DWIDTH-1:0];
    assign last_o  = head[DWIDTH];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_cnt  <= '0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_next;
            len_cnt  <= len_next;
            err_flag <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        len_next   = len_cnt;
        err_next   = err_flag;
        close_msg  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i && !is_term) begin
                    state_next = ST_IN_MSG;
                    len_next   = accept ? LEN_W'(1) : '0;
                    err_next   = drop;
                end
            end
            ST_IN_MSG: begin
                if (valid_i && !is_term) begin
                    if (accept && (len_cnt != '1)) begin
                        len_next = len_cnt + LEN_W'(1);
                    end
                    if (drop) begin
                        err_next = 1'b1;
                    end
                end else if (valid_i) begin
                    close_msg  = 1'b1;
                    state_next = ST_IDLE;
                    len_next   = '0;
                    err_next   = 1'b0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A dropped terminator still closes the message; its loss is folded into msg_err.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            msg_done <= 1'b0;
            msg_len  <= '0;
            msg_err  <= 1'b0;
        end else begin
            msg_done <= close_msg;
            if (close_msg) begin
                msg_len <= len_cnt;
                msg_err <= err_flag | drop;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dec_output_buffer.sv
// tb/tb_dec_output_buffer.sv - scoreboard bench for dec_output_buffer
module tb_dec_output_buffer;

    localparam int DEPTH  = 16;
    localparam int DWIDTH = 8;
    localparam int LEN_W  = 16;
    localparam int LW     = 5;
    localparam logic [7:0] FA = 8'hFA;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic [DWIDTH-1:0] data_i;
    logic              valid_i;
    logic [DWIDTH-1:0] data_o;
    logic              last_o;
    logic              valid_o;
    logic              ready_i;
    logic              full;
    logic [LW-1:0]     level;
    logic              msg_done;
    logic [LEN_W-1:0]  msg_len;
    logic              msg_err;
    logic              overflow;
    logic              clr_ovf;

    int total = 0;
    int bad   = 0;
    int max_lvl;

    logic [8:0]  exp_q [$];
    logic [16:0] msg_q [$];
    logic [8:0]  e_out;
    logic [16:0] e_msg;

    dec_output_buffer #(
        .DEPTH     (DEPTH),
        .DWIDTH    (DWIDTH),
        .TERM_CHAR (FA),
        .LEN_W     (LEN_W)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .data_o   (data_o),
        .last_o   (last_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .full     (full),
        .level    (level),
        .msg_done (msg_done),
        .msg_len  (msg_len),
        .msg_err  (msg_err),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop is committed at the next rising edge whenever valid_o && ready_i here.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got data %0h last %0b expected none", data_o, last_o);
                end else begin
                    e_out = exp_q.pop_front();
                    chk("out_data", 32'(data_o), 32'(e_out[7:0]));
                    chk("out_last", 32'(last_o), 32'(e_out[8]));
                end
            end
            if (msg_done) begin
                if (msg_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL msg_unexpected: got len %0d err %0b expected none", msg_len, msg_err);
                end else begin
                    e_msg = msg_q.pop_front();
                    chk("msg_len", 32'(msg_len), 32'(e_msg[15:0]));
                    chk("msg_err", 32'(msg_err), 32'(e_msg[16]));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || msg_q.size() != 0); i++) begin
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b0, 8'h00, 1'b1);
        chk({"drain_", name}, 32'(exp_q.size() + msg_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},    32'(level),    32'd0);
        chk({tag, "_valid_o"},  32'(valid_o),  32'd0);
        chk({tag, "_full"},     32'(full),     32'd0);
        chk({tag, "_data_o"},   32'(data_o),   32'd0);
        chk({tag, "_last_o"},   32'(last_o),   32'd0);
        chk({tag, "_msg_done"}, 32'(msg_done), 32'd0);
        chk({tag, "_msg_len"},  32'(msg_len),  32'd0);
        chk({tag, "_msg_err"},  32'(msg_err),  32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Basic message "HI" + terminator, streaming through.
        exp_q.push_back({1'b0, 8'h48});
        exp_q.push_back({1'b0, 8'h49});
        exp_q.push_back({1'b1, FA});
        msg_q.push_back({1'b0, 16'd2});
        step(1'b1, 8'h48, 1'b1);
        step(1'b1, 8'h49, 1'b1);
        step(1'b1, FA, 1'b1);
        wait_drain("hi");

        // Fill with the sink stalled, then overrun including the terminator.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({1'b0, 8'(8'h30 + i)});
            step(1'b1, 8'(8'h30 + i), 1'b0);
        end
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        msg_q.push_back({1'b1, 16'd16});
        step(1'b1, FA, 1'b0);
        chk("ovr_full", 32'(full), 32'd1);
        chk("ovr_level", 32'(level), 32'd16);
        chk("ovr_overflow", 32'(overflow), 32'd1);

        // Full with push and pop together: pop happens, push is dropped.
        step(1'b1, 8'h50, 1'b1);
        chk("pp_level", 32'(level), 32'd15);
        chk("pp_full", 32'(full), 32'd0);
        chk("pp_overflow", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        clr_ovf = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        exp_q.push_back({1'b1, FA});
        msg_q.push_back({1'b1, 16'd0});
        step(1'b1, FA, 1'b1);
        wait_drain("overrun");

        // Stray terminator while idle.
        step(1'b1, FA, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("stray_level", 32'(level), 32'd0);
        chk("stray_valid", 32'(valid_o), 32'd0);
        chk("stray_overflow", 32'(overflow), 32'd0);

        // Alternating push/pop across the pointer wrap.
        max_lvl = 0;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back({1'b0, 8'(8'h60 + k)});
            step(1'b1, 8'(8'h60 + k), 1'b0);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            step(1'b0, 8'h00, 1'b1);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        exp_q.push_back({1'b1, FA});
        msg_q.push_back({1'b0, 16'd20});
        step(1'b1, FA, 1'b1);
        wait_drain("wrap");
        chk("wrap_max_level_le2", 32'(max_lvl <= 2), 32'd1);

        // Reset in the middle of a message.
        step(1'b1, 8'h58, 1'b0);
        step(1'b1, 8'h59, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        msg_q.delete();
        #1;
        chk_all_zero("midrst");
        @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b1, FA});
        msg_q.push_back({1'b0, 16'd1});
        step(1'b1, 8'h41, 1'b1);
        step(1'b1, FA, 1'b1);
        wait_drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
